// File: rtl/bram_bist_pkg.sv
// Shared types and the address-derived test pattern for the block-RAM self test.
package bram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // xorshift amounts used to scramble the address key
  localparam int unsigned SHIFT_A = 13;
  localparam int unsigned SHIFT_B = 17;
  localparam int unsigned SHIFT_C = 5;

  // 32-bit pattern for an address whose low byte is key; callers slice to DATA_W
  function automatic logic [31:0] bist_pattern(input logic [7:0] key);
    logic [31:0] x;
    x = {key, ~key, key, ~key};
    x = x ^ (x << SHIFT_A);
    x = x ^ (x >> SHIFT_B);
    x = x ^ (x << SHIFT_C);
    return x;
  endfunction

endpackage

// File: rtl/bram_bist_cmp.sv
// Read-data checker: delays each issued read address by RD_LAT clocks, then
// compares the returned word against the expected pattern and accumulates errors.
module bram_bist_cmp
  import bram_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_zero_next
);

  logic [RD_LAT-1:0] vld_r;
  logic [ADDR_W-1:0] adr_r [RD_LAT];
  logic [15:0]       err_r;
  logic [15:0]       err_n;
  logic [ADDR_W-1:0] first_r;
  logic [ADDR_W-1:0] first_n;
  logic [DATA_W-1:0] exp_s;
  logic              mismatch_s;

  // Expected word, mismatch detect and next error-count / first-address values
  always_comb begin
    exp_s      = DATA_W'(bist_pattern(8'(adr_r[RD_LAT-1])));
    mismatch_s = vld_r[RD_LAT-1] && (mem_rd_data != exp_s);
    err_n      = err_r;
    first_n    = first_r;
    if (clear) begin
      err_n   = 16'h0000;
      first_n = '0;
    end else if (mismatch_s) begin
      if (err_r != 16'hFFFF) begin
        err_n = err_r + 16'h0001;
      end else begin
        err_n = err_r;
      end
      // addresses ascend, so the first mismatch of a pass is also the lowest
      if (err_r == 16'h0000) begin
        first_n = adr_r[RD_LAT-1];
      end else begin
        first_n = first_r;
      end
    end else begin
      err_n   = err_r;
      first_n = first_r;
    end
    err_zero_next = (err_n == 16'h0000);
  end

  // Address/valid delay line aligned to the memory read latency
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        adr_r[i] <= '0;
      end
    end else begin
      vld_r[0] <= rd_valid;
      adr_r[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        adr_r[i] <= adr_r[i-1];
      end
    end
  end

  // Error accumulators
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_r   <= 16'h0000;
      first_r <= '0;
    end else begin
      err_r   <= err_n;
      first_r <= first_n;
    end
  end

  assign err_count      = err_r;
  assign first_err_addr = first_r;

endmodule

// File: rtl/bram_bist.sv
// Block-RAM built-in self test: optionally writes an address-derived pattern
// over the whole memory, reads it back and reports mismatches.
module bram_bist
  import bram_bist_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 18,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  state_e            state_r;
  state_e            state_n;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_n;
  logic [1:0]        drain_r;
  logic [1:0]        drain_n;
  logic              accept_s;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [DATA_W-1:0] wr_pat_s;
  logic              err_zero_next_s;

  // Next-state, address counter and drain counter
  always_comb begin
    state_n  = state_r;
    addr_n   = addr_r;
    drain_n  = drain_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          accept_s = 1'b1;
          state_n  = mode ? WRITE : READ;
          addr_n   = '0;
          drain_n  = 2'd0;
        end else begin
          state_n = state_r;
        end
      end
      WRITE: begin
        if (addr_r == LAST_ADDR) begin
          state_n = READ;
          addr_n  = '0;
        end else begin
          addr_n = addr_r + ADDR_W'(1'b1);
        end
      end
      READ: begin
        if (addr_r == LAST_ADDR) begin
          state_n = DRAIN;
          addr_n  = '0;
          drain_n = 2'd0;
        end else begin
          addr_n = addr_r + ADDR_W'(1'b1);
        end
      end
      DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_n = DONE;
        end else begin
          drain_n = drain_r + 2'd1;
        end
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
        drain_n = 2'd0;
      end
    endcase
    wr_pat_s = DATA_W'(bist_pattern(8'(addr_n)));
  end

  // State register and registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      drain_r   <= 2'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      rd_addr_r <= '0;
    end else begin
      state_r   <= state_n;
      addr_r    <= addr_n;
      drain_r   <= drain_n;
      busy_r    <= (state_n == WRITE) || (state_n == READ) || (state_n == DRAIN);
      done_r    <= (state_n == DONE);
      pass_r    <= (state_n == DONE) && err_zero_next_s;
      wr_en_r   <= (state_n == WRITE);
      wr_addr_r <= (state_n == WRITE) ? addr_n : '0;
      wr_data_r <= (state_n == WRITE) ? wr_pat_s : '0;
      rd_addr_r <= (state_n == READ) ? addr_n : '0;
    end
  end

  bram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk            (clk),
    .resetn         (resetn),
    .clear          (accept_s),
    .rd_valid       (state_r == READ),
    .rd_addr        (rd_addr_r),
    .mem_rd_data    (mem_rd_data),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .err_zero_next  (err_zero_next_s)
  );

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign mem_wr_en   = wr_en_r;
  assign mem_wr_addr = wr_addr_r;
  assign mem_wr_data = wr_data_r;
  assign mem_rd_addr = rd_addr_r;

endmodule

// File: tb/tb_bram_bist.sv
// Self-checking bench for bram_bist: behavioural RAMs, a table of memory
// scenarios with model-derived expectations, and hand-written corner sequences.
module tb_bram_bist;
  localparam int AW = 8;
  localparam int DW = 18;
  localparam int N  = 256;
  localparam int NV = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, start1, mode1, start2;
  logic load1;

  // DUT1: RD_LAT=1 against a latency-1 RAM with per-address read fault masks
  logic busy1, done1, pass1, wen1;
  logic [15:0] err1;
  logic [AW-1:0] ferr1, wa1, ra1;
  logic [DW-1:0] wd1, rd1;
  logic [DW-1:0] mem1 [N];
  logic [DW-1:0] flip1 [N];
  logic [DW-1:0] init1 [N];

  // DUT2: RD_LAT=2 against a latency-2 RAM; DUT3: RD_LAT=1 against a latency-2 RAM
  logic busy2, done2, pass2, wen2, busy3, done3, pass3, wen3;
  logic [15:0] err2, err3;
  logic [AW-1:0] ferr2, wa2, ra2, ferr3, wa3, ra3;
  logic [DW-1:0] wd2, rd2, rd2a, wd3, rd3, rd3a;
  logic [DW-1:0] mem2 [N];
  logic [DW-1:0] mem3 [N];

  bram_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut (
    .clk(clk), .resetn(resetn), .start(start1), .mode(mode1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(ferr1),
    .mem_wr_en(wen1), .mem_wr_addr(wa1), .mem_wr_data(wd1), .mem_rd_addr(ra1), .mem_rd_data(rd1));

  bram_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .mode(1'b1),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_addr(ferr2),
    .mem_wr_en(wen2), .mem_wr_addr(wa2), .mem_wr_data(wd2), .mem_rd_addr(ra2), .mem_rd_data(rd2));

  bram_bist #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start2), .mode(1'b1),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .first_err_addr(ferr3),
    .mem_wr_en(wen3), .mem_wr_addr(wa3), .mem_wr_data(wd3), .mem_rd_addr(ra3), .mem_rd_data(rd3));

  // latency-1 RAM with preload port and read-side fault injection
  always @(posedge clk) begin
    if (load1) begin
      for (int i = 0; i < N; i++) mem1[i] <= init1[i];
    end else if (wen1) begin
      mem1[wa1] <= wd1;
    end
    rd1 <= mem1[ra1] ^ flip1[ra1];
  end

  // latency-2 RAMs
  always @(posedge clk) begin
    if (wen2) mem2[wa2] <= wd2;
    if (wen3) mem3[wa3] <= wd3;
    rd2a <= mem2[ra2];
    rd2  <= rd2a;
    rd3a <= mem3[ra3];
    rd3  <= rd3a;
  end

  typedef struct {
    bit mode;
    int exp_busy;
    int exp_err;
    int exp_first;
    bit exp_pass;
    int exp_wr;
  } vec_t;

  vec_t vt [NV];
  logic [DW-1:0] init_tab [NV][N];
  logic [DW-1:0] flip_tab [NV][N];

  int tests = 0;
  int fails = 0;

  // reference pattern built straight from the written rule with integer arithmetic
  function automatic logic [DW-1:0] pat(input int a);
    bit [31:0] x, k;
    k = 32'(a % 256);
    x = (k << 24) | ((32'd255 - k) << 16) | (k << 8) | (32'd255 - k);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x[DW-1:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // expected results of one pass from memory contents and read faults
  task automatic model(input int v);
    int cnt;
    int first;
    logic [DW-1:0] seen;
    cnt = 0;
    first = -1;
    for (int a = 0; a < N; a++) begin
      seen = (vt[v].mode ? pat(a) : init_tab[v][a]) ^ flip_tab[v][a];
      if (seen != pat(a)) begin
        cnt++;
        if (first < 0) first = a;
      end
    end
    vt[v].exp_err   = cnt;
    vt[v].exp_first = (first < 0) ? 0 : first;
    vt[v].exp_pass  = (cnt == 0);
    vt[v].exp_busy  = vt[v].mode ? 2 * N + 1 : N + 1;
    vt[v].exp_wr    = vt[v].mode ? N : 0;
  endtask

  // follow DUT1 from the first busy cycle to DONE, checking the memory-port timeline
  task automatic wait_done(input bit m, input int pulse_at, output int bcyc, output int wcyc,
                           output bit seq_ok, output logic [DW-1:0] wd0, output bit timeout);
    bit ew;
    int er;
    bcyc = 0; wcyc = 0; seq_ok = 1'b1; wd0 = '0; timeout = 1'b0;
    while (done1 !== 1'b1) begin
      if (bcyc > 3000) begin
        timeout = 1'b1;
        break;
      end
      ew = m && (bcyc < N);
      if (m) er = (bcyc >= N && bcyc < 2 * N) ? bcyc - N : 0;
      else   er = (bcyc < N) ? bcyc : 0;
      if (busy1 !== 1'b1 || wen1 !== ew || ra1 !== AW'(er)) seq_ok = 1'b0;
      if (ew && (wa1 !== AW'(bcyc) || wd1 !== pat(bcyc))) seq_ok = 1'b0;
      if (wen1) wcyc++;
      if (ew && bcyc == 0) wd0 = wd1;
      if (bcyc == pulse_at) begin
        start1 = 1'b1;
        mode1  = ~m;
      end else begin
        start1 = 1'b0;
      end
      bcyc++;
      tick();
    end
    start1 = 1'b0;
  endtask

  task automatic set_flips(input int a0, input int a1);
    for (int a = 0; a < N; a++) flip1[a] = '0;
    if (a0 >= 0) flip1[a0] = 18'h00008;
    if (a1 >= 0) flip1[a1] = 18'h00008;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err"}, err1, 0);
    chk({tag, "_ferr"}, ferr1, 0);
    chk({tag, "_wen"}, wen1, 0);
    chk({tag, "_wa"}, wa1, 0);
    chk({tag, "_wd"}, wd1, 0);
    chk({tag, "_ra"}, ra1, 0);
  endtask

  initial begin
    int bc, wc, b2;
    bit sok, to, quiet;
    logic [DW-1:0] wd0;

    resetn = 1'b0; start1 = 1'b0; mode1 = 1'b0; start2 = 1'b0; load1 = 1'b0;
    set_flips(-1, -1);
    for (int a = 0; a < N; a++) init1[a] = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    resetn = 1'b1;
    tick();

    // scenario table
    for (int v = 0; v < NV; v++)
      for (int a = 0; a < N; a++) begin
        init_tab[v][a] = '0;
        flip_tab[v][a] = '0;
      end
    flip_tab[1][5] = 18'h00008;
    flip_tab[1][9] = 18'h00008;
    for (int a = 0; a < N; a++) begin
      init_tab[3][a] = pat(a);
      init_tab[4][a] = pat(a);
      init_tab[5][a] = DW'($urandom);
      init_tab[6][a] = DW'($urandom);
      if ($urandom_range(15) == 0) flip_tab[5][a] = DW'($urandom);
    end
    repeat (8) flip_tab[4][$urandom_range(N - 1)] = DW'($urandom_range(262143, 1));
    vt[0] = '{1'b1, 513, 0, 0, 1'b1, 256};
    vt[1] = '{1'b1, 513, 2, 5, 1'b0, 256};
    vt[2].mode = 1'b0; vt[3].mode = 1'b0; vt[4].mode = 1'b0;
    vt[5].mode = 1'b1; vt[6].mode = 1'b0;
    for (int v = 2; v < NV; v++) model(v);

    for (int v = 0; v < NV; v++) begin
      for (int a = 0; a < N; a++) begin
        init1[a] = init_tab[v][a];
        flip1[a] = flip_tab[v][a];
      end
      load1 = 1'b1; tick(); load1 = 1'b0;
      start1 = 1'b1; mode1 = vt[v].mode; tick(); start1 = 1'b0;
      wait_done(vt[v].mode, -1, bc, wc, sok, wd0, to);
      chk($sformatf("v%0d_timeout", v), to, 0);
      chk($sformatf("v%0d_busy_cycles", v), bc, vt[v].exp_busy);
      chk($sformatf("v%0d_wr_cycles", v), wc, vt[v].exp_wr);
      chk($sformatf("v%0d_mem_seq", v), sok, 1);
      chk($sformatf("v%0d_done", v), done1, 1);
      chk($sformatf("v%0d_busy_in_done", v), busy1, 0);
      chk($sformatf("v%0d_err", v), err1, vt[v].exp_err);
      chk($sformatf("v%0d_first", v), ferr1, vt[v].exp_first);
      chk($sformatf("v%0d_pass", v), pass1, vt[v].exp_pass);
      if (v == 0) chk("v0_wdata_addr0", wd0, 18'h2816F);
    end

    // start pulsed mid-WRITE is ignored; results hold in DONE; start in DONE restarts
    set_flips(5, 9);
    start1 = 1'b1; mode1 = 1'b1; tick(); start1 = 1'b0;
    wait_done(1'b1, 10, bc, wc, sok, wd0, to);
    chk("ign_busy_cycles", bc, 513);
    chk("ign_mem_seq", sok, 1);
    repeat (3) tick();
    chk("hold_done", done1, 1);
    chk("hold_err", err1, 2);
    chk("hold_first", ferr1, 5);
    chk("hold_pass", pass1, 0);
    set_flips(-1, -1);
    start1 = 1'b1; mode1 = 1'b0; tick(); start1 = 1'b0;
    chk("restart_done", done1, 0);
    chk("restart_pass", pass1, 0);
    chk("restart_err", err1, 0);
    chk("restart_first", ferr1, 0);
    chk("restart_busy", busy1, 1);
    wait_done(1'b0, -1, bc, wc, sok, wd0, to);
    chk("restart_busy_cycles", bc, 257);
    chk("restart_wr_cycles", wc, 0);
    chk("restart_result", pass1, 1);

    // RD_LAT=2 memory: matched checker passes, a latency-1 checker must fail
    start2 = 1'b1; tick(); start2 = 1'b0;
    b2 = 0;
    to = 1'b0;
    while (!(done2 === 1'b1 && done3 === 1'b1)) begin
      if (b2 > 3000) begin
        to = 1'b1;
        break;
      end
      if (busy2) b2++;
      tick();
    end
    chk("lat2_timeout", to, 0);
    chk("lat2_busy_cycles", b2, 514);
    chk("lat2_pass", pass2, 1);
    chk("lat2_err", err2, 0);
    chk("lat2_mismatched_pass", pass3, 0);

    // reset for one cycle mid-READ aborts the pass
    set_flips(5, -1);
    start1 = 1'b1; mode1 = 1'b1; tick(); start1 = 1'b0;
    repeat (N + 50) tick();
    chk("midread_err_before_reset", err1, 1);
    resetn = 1'b0; tick(); resetn = 1'b1;
    chk_all_zero("midreset");
    chk("midreset_done2", done2, 0);
    quiet = 1'b1;
    repeat (5) begin
      tick();
      if (wen1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) quiet = 1'b0;
    end
    chk("midreset_quiet", quiet, 1);
    set_flips(-1, -1);
    start1 = 1'b1; mode1 = 1'b1; tick(); start1 = 1'b0;
    wait_done(1'b1, -1, bc, wc, sok, wd0, to);
    chk("fresh_busy_cycles", bc, 513);
    chk("fresh_pass", pass1, 1);
    chk("fresh_err", err1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
